arbitro_mux_3a1: RTL
====================

// Module: arbitro_mux_3a1
// PURPOSE
//  Arbiter/sequencer for the shared 3-input 32-bit datapath mux (sources Entrada1..3, Ctrl 0..2).
//  Grants the mux to one of three requesters in round-robin order and drives Ctrl, never 3.
//  Streams beats to one downstream consumer over a valid/ready handshake.
//  Caps each grant at MAX_RAFAGA beats so no source starves. Sits in front of the writeback/result bus.
// PARAMETERS
//  ANCHO       32  data width of Entrada1..3 and Dato_Out
//  MAX_RAFAGA  4   max beats per grant before forced rotation (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  Req       in   3      Req[i]=1: source i+1 has a beat on Entrada(i+1)
//  Entrada1  in   ANCHO  source 1 data (Ctrl=0)
//  Entrada2  in   ANCHO  source 2 data (Ctrl=1)
//  Entrada3  in   ANCHO  source 3 data (Ctrl=2)
//  Listo     in   1      downstream ready
//  Ctrl      out  2      mux select; registered; values 0..2 only
//  Gnt       out  3      one-hot owner; registered; 0 when idle
//  Valido    out  1      Dato_Out valid = (Gnt!=0) & |(Gnt & Req)
//  Dato_Out  out  ANCHO  selected Entrada per Ctrl (combinational mux)
//  Ack       out  3      Gnt & {3{Valido & Listo}}; beat accepted this cycle
// BEHAVIOUR
//  - FSM: IDLE, GRANT. Ptr (2b) = first source searched next, always 0..2.
//  - Reset: state=IDLE, Ctrl=0, Gnt=0, Ptr=0, beat counter=0; Valido=0, Ack=0.
//    Dato_Out follows Ctrl=0, i.e. Entrada1.
//  - Reset mid-burst: takes effect on the same edge; no Ack in the reset cycle; the
//    in-flight beat is dropped.
//  - Win(R): first set bit of R, scanning Ptr, Ptr+1, Ptr+2 (mod 3).
//  - IDLE, Req!=0: next edge -> GRANT, Gnt=onehot(win), Ctrl=win, cnt=0. Latency 1 clk.
//  - IDLE, Req==0: stay; Ctrl holds last value.
//  - GRANT: a transfer occurs when Valido & Listo. On each transfer, cnt++.
//  - Release in GRANT is one of:
//    (a) owner Req=0 (no transfer that cycle);
//    (b) transfer of beat number MAX_RAFAGA.
//  - On release: Ptr=owner+1 mod 3; cnt=0.
//    If any Req bit other than the owner's is set -> GRANT to Win(Req & ~Gnt) on the next edge.
//    If only the owner's bit is set (case b) -> regrant the owner.
//    If Req==0 -> IDLE.
//    No bubble cycle when a switch occurs.
//  - Valido=1 & Listo=0: hold Gnt, Ctrl and cnt. The source must hold its data (no timeout).
//  - Owner drops Req while stalled: treated as release (a); no Ack is issued.
//  - Simultaneous requests: the round-robin pointer decides.
//    After reset, Entrada1 > Entrada2 > Entrada3.
//  - Gnt is always one-hot or zero. Ctrl==3 is unreachable; a bench assertion checks this.
// CONFIGURATION
//  ARB_PRIORIDAD_FIJA_EN defined: Ptr is forced to 0, giving fixed priority Entrada1 > 2 > 3.
//    MAX_RAFAGA still forces release; re-arbitration then favours the lowest index,
//    including the previous owner.
//  ARB_PRIORIDAD_FIJA_EN undefined (default): round-robin as above.
// TESTING
//  1 Reset: Req=3'b111, reset=1 for 2 clk -> Gnt=0, Ctrl=0, Valido=0, Ack=0 throughout.
//  2 Single source: Req=3'b010, Entrada2=2, Listo=1.
//    -> 1 clk later Gnt=010, Ctrl=1, Dato_Out=2.
//    -> 4 Acks, then 1 release cycle with Ack=0, then the regrant cycle.
//  3 Round-robin: Req=3'b111, Listo=1, MAX_RAFAGA=4.
//    -> Ctrl sequence 0,1,2,0 with 4 beats each; no idle cycle between owners.
//  4 Backpressure: owner 1 granted, Listo=0 for 5 clk.
//    -> Valido=1, Ack=0, Gnt and cnt stable.
//    -> Listo=1 -> Ack on the same cycle.
//  5 Early drop: Req=3'b101, owner 0 drops Req after 2 beats.
//    -> next edge Gnt=100, Ctrl=2, Dato_Out=Entrada3=3.
//  6 Mid-burst reset, then with ARB_PRIORIDAD_FIJA_EN defined and Req=3'b110.
//    -> reset: all outputs go to reset values on the next edge.
//    -> fixed priority: Gnt=010 repeatedly, source 3 starves.

Source files
------------

// File: rtl/arbitro_mux_3a1.sv
// arbitro_mux_3a1: round-robin arbiter driving a shared 3:1 data mux with valid/ready beats
//   Ports: clk, reset (sync, active-high), Req[2:0] per-source requests,
//   Entrada1..3 source data, Listo downstream ready, Ctrl mux select (0..2),
//   Gnt one-hot owner, Valido beat valid, Dato_Out muxed data, Ack beat accepted.
//   Config: define ARB_PRIORIDAD_FIJA_EN for fixed priority Entrada1 > Entrada2 > Entrada3.
module arbitro_mux_3a1 #(
    parameter int ANCHO      = 32,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       Req,
    input  logic [ANCHO-1:0] Entrada1,
    input  logic [ANCHO-1:0] Entrada2,
    input  logic [ANCHO-1:0] Entrada3,
    input  logic             Listo,
    output logic [1:0]       Ctrl,
    output logic [2:0]       Gnt,
    output logic             Valido,
    output logic [ANCHO-1:0] Dato_Out,
    output logic [2:0]       Ack
);
    localparam int CW = $clog2(MAX_RAFAGA + 1);
    typedef enum logic {IDLE, GRANT} estado_t;
    estado_t       r_estado, w_estado;
    logic [1:0]    r_ctrl, w_ctrl, r_ptr, w_ptr, w_pnext, w_start;
    logic [2:0]    r_gnt, w_gnt, w_cand;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          w_xfer, w_rel;
    // first set bit of r scanning p, p+1, p+2 (mod 3); caller guarantees r != 0
    function automatic logic [1:0] win(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] i1, i2;
        i1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
        i2 = (p == 2'd0) ? 2'd2 : p - 2'd1;
        return r[p] ? p : r[i1] ? i1 : i2;
    endfunction
    assign Ctrl     = r_ctrl;
    assign Gnt      = r_gnt;
    // gated by reset so the cycle carrying reset never accepts a beat
    assign Valido   = ~reset & |(r_gnt & Req);
    assign w_xfer   = Valido & Listo;
    assign Ack      = r_gnt & {3{w_xfer}};
    assign Dato_Out = (r_ctrl == 2'd0) ? Entrada1 : (r_ctrl == 2'd1) ? Entrada2 : Entrada3;
    always_comb begin
        w_estado = r_estado;
        w_ctrl   = r_ctrl;
        w_gnt    = r_gnt;
        w_ptr    = r_ptr;
        w_cnt    = r_cnt;
        w_pnext  = (r_ctrl == 2'd2) ? 2'd0 : r_ctrl + 2'd1;
`ifdef ARB_PRIORIDAD_FIJA_EN
        w_start  = 2'd0;
        w_cand   = Req;
`else
        w_start  = w_pnext;
        w_cand   = Req & ~r_gnt;
`endif
        // owner idle (no beat) or last beat of the burst accepted
        w_rel    = (r_estado == GRANT) && (!Valido || (w_xfer && r_cnt == CW'(MAX_RAFAGA - 1)));
        if (r_estado == IDLE) begin
            if (|Req) begin
                w_estado = GRANT;
                w_ctrl   = win(Req, r_ptr);
                w_gnt    = 3'b001 << w_ctrl;
                w_cnt    = '0;
            end
        end else if (w_rel) begin
            w_ptr = w_start;
            w_cnt = '0;
            // a lone owner re-enters via IDLE, costing one cycle; a switch has no bubble
            if (|w_cand) begin
                w_ctrl = win(w_cand, w_start);
                w_gnt  = 3'b001 << w_ctrl;
            end else begin
                w_estado = IDLE;
                w_gnt    = 3'b000;
            end
        end else if (w_xfer) begin
            w_cnt = r_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= IDLE;
            r_ctrl   <= 2'd0;
            r_gnt    <= 3'b000;
            r_ptr    <= 2'd0;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estado;
            r_ctrl   <= w_ctrl;
            r_gnt    <= w_gnt;
            r_ptr    <= w_ptr;
            r_cnt    <= w_cnt;
        end
    end
endmodule
